// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Accepts unsigned or two's-complement operands; reports sign, overflow and leading-zero digits.
module bin2bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  signed_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [BIN_W-1:0]   mag;
    logic [BCD_W-1:0]   digits;
    logic               ovf_acc;
    logic               sign_r;
    logic [CNT_W-1:0]   cnt;

    logic [BIN_W-1:0]   bin_neg;
    logic               is_neg;
    logic [BCD_W-1:0]   digits_adj;
    logic [BCD_W-1:0]   digits_shf;
    logic [BIN_W-1:0]   mag_shf;
    logic               ovf_bit;
    logic               last_shift;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Digit 0 is never flagged, so a zero result still displays one digit.
    function automatic logic [DIGITS-1:0] lead_zeros(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] m;
        logic              all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (d[4*i +: 4] == 4'd0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

    // Negating -2^(BIN_W-1) yields the same bit pattern, which read unsigned is the correct magnitude.
    assign bin_neg    = ~bin_in + {{(BIN_W-1){1'b0}}, 1'b1};
    assign is_neg     = signed_mode & bin_in[BIN_W-1];

    assign digits_adj = add3(digits);
    assign ovf_bit    = digits_adj[BCD_W-1];
    assign digits_shf = {digits_adj[BCD_W-2:0], mag[BIN_W-1]};
    assign mag_shf    = {mag[BIN_W-2:0], 1'b0};
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mag      <= '0;
            digits   <= '0;
            ovf_acc  <= 1'b0;
            sign_r   <= 1'b0;
            cnt      <= '0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
            overflow <= 1'b0;
            lz_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag     <= is_neg ? bin_neg : bin_in;
                        sign_r  <= is_neg;
                        digits  <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    digits  <= digits_shf;
                    mag     <= mag_shf;
                    ovf_acc <= ovf_acc | ovf_bit;
                    cnt     <= cnt + CNT_W'(1);
                    // Result registers update only on the edge entering DONE and hold until the next one.
                    if (last_shift) begin
                        bcd_out  <= digits_shf;
                        sign_out <= sign_r;
                        overflow <= ovf_acc | ovf_bit;
                        lz_mask  <= lead_zeros(digits_shf);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL provide parameter BIN_W, default 12, meaning binary input width in bits (legal range 4..32).
REQ-002 SHALL provide parameter DIGITS, default 4, meaning number of BCD output digits (legal range 1..10).
REQ-003 SHALL provide port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-004 SHALL provide port n_rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL provide port bin_in, input, BIN_W, binary operand.
REQ-006 SHALL provide port signed_mode, input, 1, 1 = bin_in is two's complement; 0 = unsigned.
REQ-007 SHALL provide port in_valid, input, 1, operand present.
REQ-008 SHALL provide port in_ready, output, 1, converter can accept an operand.
REQ-009 SHALL provide port bcd_out, output, 4*DIGITS, result; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-010 SHALL provide port sign_out, output, 1, result is negative.
REQ-011 SHALL provide port overflow, output, 1, magnitude exceeds 10^DIGITS-1.
REQ-012 SHALL provide port lz_mask, output, DIGITS, bit i = 1 when digit i is a leading zero.
REQ-013 SHALL provide port out_valid, output, 1, result present.
REQ-014 SHALL provide port out_ready, input, 1, consumer accepts the result.

Function
REQ-015 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE, both decoded directly from the state register.
REQ-017 SHALL, in IDLE on a clock edge with in_valid=1, capture bin_in and signed_mode, clear the digit register, overflow accumulator and cycle counter, and go to SHIFT.
REQ-018 SHALL form the captured magnitude as the two's complement negation of bin_in when signed_mode=1 and bin_in[BIN_W-1]=1, setting the internal sign to 1; otherwise magnitude = bin_in and sign = 0.
REQ-019 SHALL encode the magnitude of -2^(BIN_W-1) as unsigned 2^(BIN_W-1).
REQ-020 SHALL, in each SHIFT cycle, first add 3 to every digit >= 5, then shift {digits, magnitude} left one bit, MSB of the magnitude entering digit 0 bit 0.
REQ-021 SHALL OR the bit shifted out of the top digit into the overflow accumulator on every SHIFT cycle.
REQ-022 SHALL perform exactly BIN_W SHIFT cycles, then go to DONE, so out_valid rises exactly BIN_W cycles after the accepting edge.
REQ-023 SHALL, on the edge entering DONE, load bcd_out, sign_out, overflow and lz_mask from the final internal values; on overflow the digits hold the magnitude modulo 10^DIGITS.
REQ-024 SHALL set lz_mask bit i (i >= 1) when digit i and all higher digits are zero; bit 0 SHALL always be 0.
REQ-025 SHALL remain in DONE with all outputs stable while out_ready=0.
REQ-026 SHALL return to IDLE on the edge where out_valid=1 and out_ready=1, so minimum throughput is one operand per BIN_W+2 cycles.
REQ-027 SHALL ignore in_valid in SHIFT and DONE; the operand is neither captured nor queued.
REQ-028 SHALL hold bcd_out, sign_out, overflow and lz_mask unchanged from leaving DONE until the next entry into DONE.
REQ-029 SHALL size the cycle counter as clog2(BIN_W+1) bits with no wrap-around during a conversion.

Reset
REQ-030 SHALL, while n_rst=0, force state IDLE, so in_ready=1 and out_valid=0.
REQ-031 SHALL, while n_rst=0, force bcd_out=0, sign_out=0, overflow=0, lz_mask=0 and clear all internal registers.
REQ-032 SHALL, on reset asserted during SHIFT or DONE, abort the conversion and discard the pending result.
REQ-033 SHALL accept a new operand on the first rising edge after reset release when in_valid=1.

Verification
REQ-034 SHALL be verified with defaults, unsigned bin_in=4095 -> out_valid 12 cycles after accept, bcd_out=0x4095, overflow=0, lz_mask=0000.
REQ-035 SHALL be verified with signed_mode=1 and bin_in=0x800 -> sign_out=1, bcd_out=0x2048; separately bin_in=0xFFF -> sign_out=1, bcd_out=0x0001, lz_mask=1110.
REQ-036 SHALL be verified with bin_in=0 -> bcd_out=0x0000, sign_out=0, lz_mask=1110.
REQ-037 SHALL be verified with DIGITS=3 and bin_in=1234 -> bcd_out=0x234, overflow=1; with DIGITS=3 and bin_in=999 -> overflow=0.
REQ-038 SHALL be verified with out_ready held low 5 cycles and in_valid pulsed in SHIFT and DONE -> outputs stable, pulses ignored, IDLE one cycle after the out_ready=1 edge.
REQ-039 SHALL be verified with n_rst pulsed low at SHIFT cycle 6 -> out_valid never asserts, outputs 0; next operand 37 -> bcd_out=0x0037.
